// File: rtl/prog_loader_pkg.sv
// Shared types and framing constants for the program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 8-to-32 word assembler with running XOR of accepted bytes.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          word_ready,
  output logic [7:0]                    csum
);

  logic [IDX_W-1:0] idx;

  // Last lane of the word being accepted this cycle.
  assign word_ready = in_valid && (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Lane fill, index advance (wraps per word) and checksum accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
      csum <= '0;
    end else if (clr) begin
      idx  <= '0;
      csum <= '0;
    end else if (in_valid) begin
      word[idx*8 +: 8] <= in_byte;
      idx              <= idx + 1'b1;
      csum             <= csum ^ in_byte;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: fills instruction RAM from a framed byte
// stream and releases the core only after a verified load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 9,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  output logic                 byte_ready,
  output logic                 mem_we,
  output logic [RAM_DEPTH-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned            CAP   = END_ADDR - START_ADDR + 1;
  localparam logic [RAM_DEPTH-1:0]   ADDR0 = RAM_DEPTH'(START_ADDR);
  localparam int                     LEN_W = 8 * LEN_BYTES;

  state_t             state, state_n;
  logic [7:0]         len_lo;
  logic [LEN_W-1:0]   len_n, words_left;
  logic               hs, start_ok, last_word, pk_valid, word_ready;
  logic [7:0]         csum;

  assign hs        = byte_valid && byte_ready;
  assign start_ok  = start && (state inside {S_IDLE, S_DONE, S_ERR});
  assign len_n     = {byte_data, len_lo};
  assign last_word = (words_left == LEN_W'(1));
  assign pk_valid  = (state == S_DATA) && byte_valid;

  // Word assembly only 32-bit wide; mem_wdata is driven straight from it.
  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (start_ok),
    .in_valid   (pk_valid),
    .in_byte    (byte_data),
    .word       (mem_wdata),
    .word_ready (word_ready),
    .csum       (csum)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state decode plus handshake/write strobes.
  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LEN_LO;
      S_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (32'(len_n) > CAP)      state_n = S_ERR;
          else if (len_n == '0)      state_n = S_CHECK;
          else                       state_n = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (word_ready) state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_we  = 1'b1;
        state_n = last_word ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_n = (byte_data == csum) ? S_DONE : S_ERR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Length capture, address/word counting and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo     <= '0;
      words_left <= '0;
      mem_addr   <= ADDR0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (start_ok) begin
        mem_addr  <= ADDR0;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end
      if (state == S_LEN_LO && hs) len_lo     <= byte_data;
      if (state == S_LEN_HI && hs) words_left <= len_n;
      if (state == S_WRITE) begin
        words_left <= words_left - 1'b1;
        // Holding on the last word keeps mem_addr within END_ADDR.
        if (!last_word) mem_addr <= mem_addr + 1'b1;
      end
      if (state_n == S_DONE && state != S_DONE) begin
        cpu_reset <= 1'b0;
        done      <= 1'b1;
      end
      if (state_n == S_ERR && state != S_ERR) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of frames plus hand-written
// latency and mid-load reset sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_reset, done, error;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0]  wa_q[$];
  logic [31:0] wd_q[$];

  typedef struct {
    logic [27:0][7:0] b;
    int               nb;
    int               nw;
    logic [5:0][31:0] w;
    int               gap;
    logic             e_done, e_err, e_cpu;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Record every RAM write; byte_ready must be low while writing.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      chk("ready_in_write", {31'b0, byte_ready}, 32'd0);
    end
  end

  function automatic vec_t build(input int n, input logic [5:0][31:0] w,
                                 input bit bad, input int gap);
    vec_t v;
    logic [7:0] cs;
    cs    = 8'h00;
    v.b   = '0;
    v.w   = w;
    v.nb  = 2 + 4*n + 1;
    v.nw  = n;
    v.gap = gap;
    v.b[0] = 8'(n);
    v.b[1] = 8'(n >> 8);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) begin
        v.b[2 + 4*k + j] = w[k][8*j +: 8];
        cs = cs ^ w[k][8*j +: 8];
      end
    v.b[2 + 4*n] = bad ? (cs ^ 8'h03) : cs;
    v.e_done = !bad;
    v.e_err  = bad;
    v.e_cpu  = bad;
    return v;
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (byte_ready) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: byte %h never accepted", b);
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'b0, mem_we},     32'd0);
    chk({tag, "_addr"},  {23'b0, mem_addr},   32'd0);
    chk({tag, "_wdata"}, mem_wdata,           32'd0);
    chk({tag, "_cpu"},   {31'b0, cpu_reset},  32'd1);
    chk({tag, "_done"},  {31'b0, done},       32'd0);
    chk({tag, "_err"},   {31'b0, error},      32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    chk($sformatf("v%0d_cpu_on_start", id),  {31'b0, cpu_reset}, 32'd1);
    chk($sformatf("v%0d_done_on_start", id), {31'b0, done},      32'd0);
    chk($sformatf("v%0d_err_on_start", id),  {31'b0, error},     32'd0);
    for (int k = 0; k < v.nb; k++)
      send(v.b[k], (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_nwrites", id), wa_q.size(), v.nw);
    for (int k = 0; k < v.nw && k < wa_q.size(); k++) begin
      chk($sformatf("v%0d_addr%0d", id, k), {23'b0, wa_q[k]}, k);
      chk($sformatf("v%0d_data%0d", id, k), wd_q[k], v.w[k]);
    end
    chk($sformatf("v%0d_done", id),  {31'b0, done},       {31'b0, v.e_done});
    chk($sformatf("v%0d_err", id),   {31'b0, error},      {31'b0, v.e_err});
    chk($sformatf("v%0d_cpu", id),   {31'b0, cpu_reset},  {31'b0, v.e_cpu});
    chk($sformatf("v%0d_ready", id), {31'b0, byte_ready}, 32'd0);
  endtask

  initial begin
    logic [5:0][31:0] nom, full;
    nom  = {{4{32'h0}}, 32'h00108133, 32'h00500093};
    full = {32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF,
            32'h00000013, 32'h80000000, 32'h0A0B0C0D};

    tv[0] = build(2, nom, 1'b0, 0);        // nominal
    tv[1] = build(0, '0, 1'b0, 0);         // zero length: 00 00 00
    tv[2] = build(0, '0, 1'b0, 0);         // oversize 7 > capacity 6
    tv[2].b[0] = 8'h07; tv[2].nb = 2;
    tv[2].e_done = 1'b0; tv[2].e_err = 1'b1; tv[2].e_cpu = 1'b1;
    tv[3] = build(2, nom, 1'b1, 0);        // checksum 0x62
    tv[4] = build(2, nom, 1'b0, 3);        // valid gaps
    tv[5] = build(6, full, 1'b0, 0);       // exactly full capacity
    tv[6] = build(0, '0, 1'b0, 0);         // length 0x0100 via high byte
    tv[6].b[1] = 8'h01; tv[6].nb = 2;
    tv[6].e_done = 1'b0; tv[6].e_err = 1'b1; tv[6].e_cpu = 1'b1;

    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    #12;
    check_reset_vals("rst0");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tv[i], i);

    // Write latency and mid-load reset.
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    send(8'h02, 0); send(8'h00, 0); send(8'h93, 0);
    send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
    chk("lat_we",   {31'b0, mem_we},     32'd1);
    chk("lat_addr", {23'b0, mem_addr},   32'd0);
    chk("lat_data", mem_wdata,           32'h00500093);
    chk("lat_rdy",  {31'b0, byte_ready}, 32'd0);
    @(negedge clk);
    chk("post_wr_addr", {23'b0, mem_addr}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Bytes offered while idle must be ignored.
    for (int k = 0; k < 6; k++) begin
      byte_valid = 1'b1;
      byte_data  = 8'(8'hA0 + k);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("midrst_nwrites", wa_q.size(), 32'd1);
    chk("idle_ready",     {31'b0, byte_ready}, 32'd0);
    chk("idle_cpu",       {31'b0, cpu_reset},  32'd1);
    run_vec(tv[0], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
